cfg_wrr_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter with per-requestor programmable weights and a valid/ready grant handshake. It is the successor to the team's fixed weighted round-robin arbiter. Each requestor receives up to `weight[i]` consecutive accepted grants before priority rotates. The grant is registered and held stable under downstream backpressure. It sits between request sources, such as DMA channels or bus masters, and a shared single-consumer resource.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 26 ++
 rtl/cfg_wrr_arbiter.sv | 106 ++++++++++
 tb/tb_cfg_wrr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: index width, default sizes and weight-field access.
package arb_pkg;

    localparam int REQ_NUM_DEF  = 8;
    localparam int WEIGHT_W_DEF = 4;
    localparam int VMAX         = 1024;
    localparam int FMAX         = 32;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Packed vector is zero-extended to VMAX by the caller.
    function automatic logic [FMAX-1:0] wfield(input logic [VMAX-1:0] v,
                                               input int i, input int w);
        logic [FMAX-1:0] m;
        m = FMAX'((64'd1 << w) - 64'd1);
        return FMAX'(v >> (i * w)) & m;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-one finder: lowest offset from start whose eligible bit is set.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    int j;

    always_comb begin
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N;
            if (elig[j])
                idx = IW'(j);
        end
    end

    assign found = |elig;

endmodule

// File: rtl/cfg_wrr_arbiter.sv
// Weighted round-robin arbiter with programmable weights and valid/ready grant.
// Define CFG_WRR_LOCK_EN to add the lock input that pins the owner.
module cfg_wrr_arbiter
    import arb_pkg::*;
#(
    parameter  int REQ_NUM  = REQ_NUM_DEF,
    parameter  int WEIGHT_W = WEIGHT_W_DEF,
    localparam int IDX_W    = idx_w(REQ_NUM)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [REQ_NUM-1:0]           reqs,
    input  logic [REQ_NUM*WEIGHT_W-1:0]  weights,
    input  logic                         grant_ready,
`ifdef CFG_WRR_LOCK_EN
    input  logic                         lock,
`endif
    output logic                         grant_valid,
    output logic [REQ_NUM-1:0]           grants,
    output logic [IDX_W-1:0]             grant_idx
);

    logic                gv, nxt_gv;
    logic [REQ_NUM-1:0]  gnt_q, nxt_gnt;
    logic [IDX_W-1:0]    cur, nxt_cur;
    logic [IDX_W-1:0]    ptr, nxt_ptr;
    logic [WEIGHT_W-1:0] cnt, nxt_cnt;

    logic [WEIGHT_W-1:0] wt [REQ_NUM];
    logic [REQ_NUM-1:0]  elig;
    logic [IDX_W-1:0]    cur_inc, pk_inc, start, pk;
    logic                found, upd, acc, own, lk;

`ifdef CFG_WRR_LOCK_EN
    assign lk = lock;
`else
    assign lk = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            wt[i]   = WEIGHT_W'(wfield(VMAX'(weights), i, WEIGHT_W));
            elig[i] = reqs[i] && (wt[i] != '0);
        end
    end

    assign upd     = !gv || grant_ready;
    assign acc     = gv && grant_ready;
    assign own     = reqs[cur];
    assign cur_inc = (cur == IDX_W'(REQ_NUM - 1)) ? '0 : cur + 1'b1;
    assign pk_inc  = (pk == IDX_W'(REQ_NUM - 1)) ? '0 : pk + 1'b1;
    assign start   = acc ? cur_inc : ptr;

    rr_pick #(.N(REQ_NUM), .IW(IDX_W)) u_pick (
        .elig  (elig),
        .start (start),
        .found (found),
        .idx   (pk)
    );

    // Priority: lock hold, burst continue, search, idle.
    always_comb begin
        nxt_gv  = gv;
        nxt_gnt = gnt_q;
        nxt_cur = cur;
        nxt_ptr = ptr;
        nxt_cnt = cnt;
        if (upd) begin
            if (acc && lk && own) begin
                nxt_cnt = cnt;
            end else if (acc && own && cnt > WEIGHT_W'(1)) begin
                nxt_cnt = cnt - WEIGHT_W'(1);
            end else if (found) begin
                nxt_gv  = 1'b1;
                nxt_gnt = REQ_NUM'(1) << pk;
                nxt_cur = pk;
                nxt_cnt = wt[pk];
                nxt_ptr = pk_inc;
            end else begin
                nxt_gv  = 1'b0;
                nxt_gnt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gv    <= 1'b0;
            gnt_q <= '0;
            cur   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            gv    <= nxt_gv;
            gnt_q <= nxt_gnt;
            cur   <= nxt_cur;
            ptr   <= nxt_ptr;
            cnt   <= nxt_cnt;
        end
    end

    assign grant_valid = gv;
    assign grants      = gnt_q;
    assign grant_idx   = cur;

endmodule

// File: tb/tb_cfg_wrr_arbiter.sv
// Directed and random checks of cfg_wrr_arbiter against a rule-level model.
module tb_cfg_wrr_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  reqs;
    logic [N*W-1:0] weights;
    logic          grant_ready;
    logic          lock_in;
    logic          grant_valid;
    logic [N-1:0]  grants;
    logic [IW-1:0] grant_idx;

    int checks = 0;
    int failures = 0;

    bit m_v;
    int m_cur, m_cnt, m_ptr;

    always #5 clk = ~clk;

    cfg_wrr_arbiter #(.REQ_NUM(N), .WEIGHT_W(W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .reqs        (reqs),
        .weights     (weights),
        .grant_ready (grant_ready),
`ifdef CFG_WRR_LOCK_EN
        .lock        (lock_in),
`endif
        .grant_valid (grant_valid),
        .grants      (grants),
        .grant_idx   (grant_idx)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wgt(input int j);
        return int'(weights[j*W +: W]);
    endfunction

    function automatic void m_reset();
        m_v = 0; m_cur = 0; m_cnt = 0; m_ptr = 0;
    endfunction

    // One clock edge of the arbitration rules, on the inputs seen at that edge.
    function automatic void m_edge();
        bit acc, lk, hit;
        int s, j;
        lk = 0;
`ifdef CFG_WRR_LOCK_EN
        lk = lock_in;
`endif
        if (!rstn) begin
            m_reset();
            return;
        end
        if (m_v && !grant_ready) return;
        acc = m_v && grant_ready;
        if (acc && lk && reqs[m_cur]) return;
        if (acc && reqs[m_cur] && m_cnt > 1) begin
            m_cnt--;
            return;
        end
        s = acc ? (m_cur + 1) % N : m_ptr;
        hit = 0;
        for (int k = 0; k < N; k++) begin
            j = (s + k) % N;
            if (!hit && reqs[j] && wgt(j) != 0) begin
                hit = 1;
                m_cur = j;
            end
        end
        if (hit) begin
            m_v = 1;
            m_cnt = wgt(m_cur);
            m_ptr = (m_cur + 1) % N;
        end else begin
            m_v = 0;
        end
    endfunction

    task automatic cmp_model();
        chk("valid", 32'(grant_valid), 32'(m_v));
        chk("grants", 32'(grants), m_v ? (32'd1 << m_cur) : 32'd0);
        chk("idx", 32'(grant_idx), 32'(m_cur));
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        weights = {W'(w3), W'(w2), W'(w1), W'(w0)};
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    initial begin : main
        int seq2 [6] = '{0, 1, 2, 3, 0, 1};
        int seq3 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        rstn = 1'b0;
        reqs = 4'b1111;
        grant_ready = 1'b1;
        lock_in = 1'b0;
        set_w(1, 1, 1, 1);
        m_reset();
        @(negedge clk);

        // Reset with all requests, then idle release
        step();
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_grants", 32'(grants), 32'd0);
        reqs = 4'b0000;
        rstn = 1'b1;
        repeat (3) step();
        chk("idle_valid", 32'(grant_valid), 32'd0);

        // Equal weights
        reqs = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("eq_seq", 32'(grant_idx), 32'(seq2[k]));
        end

        // Unequal weights
        reqs = 4'b0000;
        do_reset();
        set_w(3, 1, 0, 0);
        reqs = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("uneq_seq", 32'(grant_idx), 32'(seq3[k]));
        end

        // Backpressure after the second grant to 0
        reqs = 4'b0000;
        do_reset();
        reqs = 4'b0011;
        step();
        step();
        chk("bp_idx", 32'(grant_idx), 32'd0);
        grant_ready = 1'b0;
        repeat (3) begin
            step();
            chk("bp_hold", 32'(grants), 32'b0001);
        end
        grant_ready = 1'b1;
        step();
        chk("bp_rel0", 32'(grant_idx), 32'd0);
        step();
        chk("bp_rel1", 32'(grant_idx), 32'd1);

        // Async reset mid-burst clears immediately
        rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(grant_valid), 32'd0);
        chk("arst_idx", 32'(grant_idx), 32'd0);
        m_reset();
        step();
        rstn = 1'b1;

        // Zero weight masks; owner drop forces search
        set_w(1, 1, 0, 1);
        reqs = 4'b0100;
        repeat (4) begin
            step();
            chk("mask_valid", 32'(grant_valid), 32'd0);
        end
        set_w(4, 1, 0, 1);
        reqs = 4'b0011;
        step();
        chk("drop_first", 32'(grant_idx), 32'd0);
        reqs = 4'b0010;
        step();
        chk("drop_next", 32'(grant_idx), 32'd1);

`ifdef CFG_WRR_LOCK_EN
        reqs = 4'b0000;
        do_reset();
        set_w(1, 1, 1, 1);
        reqs = 4'b0011;
        step();
        lock_in = 1'b1;
        repeat (4) begin
            step();
            chk("lock_hold", 32'(grant_idx), 32'd0);
        end
        lock_in = 1'b0;
        step();
        chk("lock_rel", 32'(grant_idx), 32'd1);
`endif

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0)
                set_w($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                reqs = N'($urandom);
            grant_ready = ($urandom_range(0, 3) != 0);
            lock_in = ($urandom_range(0, 4) == 0);
            rstn = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
